// File: rtl/cache_cmd_sequencer_if.sv
// Command-in handshake plus issue-side outputs of the cache command sequencer.
interface cache_cmd_sequencer_if #(
    parameter int unsigned CMD_W = 41,
    parameter int unsigned CNT_W = 16
);
    logic [CMD_W-1:0] cmd_in;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             hold;
    logic [CMD_W-1:0] instruction;
    logic [11:0]      tag;
    logic [13:0]      index;
    logic [5:0]       offset;
    logic             sel_d;
    logic             sel_i;
    logic             read_enable;
    logic             write_enable;
    logic             start;
    logic             clear;
    logic             print;
    logic             idle;
    logic [CNT_W-1:0] issued_count;

    // Trace loader / downstream control side
    modport master (
        output cmd_in, cmd_valid, hold,
        input  cmd_ready, instruction, tag, index, offset, sel_d, sel_i,
               read_enable, write_enable, start, clear, print, idle, issued_count
    );

    // Sequencer side
    modport slave (
        input  cmd_in, cmd_valid, hold,
        output cmd_ready, instruction, tag, index, offset, sel_d, sel_i,
               read_enable, write_enable, start, clear, print, idle, issued_count
    );
endinterface

// File: rtl/cache_cmd_sequencer.sv
// Buffers trace commands in a FIFO, decodes them and drives the two-phase
// lookup/update enables for the split L1 caches, or clear/print pulses.
module cache_cmd_sequencer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CMD_W = 41,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_cmd_sequencer_if.slave bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = AW + 1;
    localparam int unsigned N_MSB    = CMD_W - 1;
    localparam int unsigned ADDR_LSB = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_UPDATE,
        S_CLEAR,
        S_PRINT
    } state_t;

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_c;
    logic             pop_c;
    logic             retire_c;
    logic [CMD_W-1:0] head_c;
    logic [3:0]       head_n_c;
    logic [3:0]       cur_n_c;
    logic             is_d_c;
    logic             is_i_c;

    state_t           state_q;
    state_t           state_d;
    logic [CMD_W-1:0] instr_q;
    logic             sel_d_q;
    logic             sel_i_q;
    logic             rd_en_q;
    logic             wr_en_q;
    logic             start_q;
    logic             clear_q;
    logic             print_q;
    logic             idle_q;
    logic [CNT_W-1:0] issued_q;

    assign bus.cmd_ready = (count_q < CW'(DEPTH));
    assign push_c        = bus.cmd_valid && bus.cmd_ready;
    assign pop_c         = !bus.hold && (state_q == S_IDLE) && (count_q != '0);
    assign retire_c      = !bus.hold && ((state_q == S_UPDATE) || (state_q == S_CLEAR) ||
                                         (state_q == S_PRINT));
    assign head_c        = mem_q[rd_ptr_q];
    assign head_n_c      = head_c[N_MSB -: 4];
    assign cur_n_c       = instr_q[N_MSB -: 4];
    assign is_i_c        = (cur_n_c == 4'd2);
    assign is_d_c        = (cur_n_c <= 4'd6) && !is_i_c;

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.cmd_in;
        end
    end

    // FIFO pointers and count; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Next-state decode; unsupported opcodes are popped and dropped in IDLE
    always_comb begin
        state_d = state_q;
        if (!bus.hold) begin
            case (state_q)
                S_IDLE: begin
                    if (pop_c) begin
                        if (head_n_c <= 4'd6)      state_d = S_LOOKUP;
                        else if (head_n_c == 4'd8) state_d = S_CLEAR;
                        else if (head_n_c == 4'd9) state_d = S_PRINT;
                        else                       state_d = S_IDLE;
                    end
                end
                S_LOOKUP: state_d = S_UPDATE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // State register and registered issue outputs; everything freezes under hold
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            instr_q  <= {4'b1000, (CMD_W-4)'(0)};
            sel_d_q  <= 1'b0;
            sel_i_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            start_q  <= 1'b0;
            clear_q  <= 1'b0;
            print_q  <= 1'b0;
            idle_q   <= 1'b1;
            issued_q <= '0;
        end else if (!bus.hold) begin
            state_q <= state_d;
            idle_q  <= (state_d == S_IDLE) && (count_d == '0);
            rd_en_q <= (state_q == S_LOOKUP);
            start_q <= (state_q == S_LOOKUP);
            wr_en_q <= (state_q == S_UPDATE);
            clear_q <= (state_q == S_CLEAR);
            print_q <= (state_q == S_PRINT);
            // Cache select spans both the lookup and update phases
            if (state_q == S_LOOKUP) begin
                sel_d_q <= is_d_c;
                sel_i_q <= is_i_c;
            end else if (state_q != S_UPDATE) begin
                sel_d_q <= 1'b0;
                sel_i_q <= 1'b0;
            end
            if (pop_c) begin
                instr_q <= head_c;
            end
            if (retire_c && (issued_q != {CNT_W{1'b1}})) begin
                issued_q <= issued_q + CNT_W'(1);
            end
        end
    end

    assign bus.instruction  = instr_q;
    assign bus.tag          = instr_q[ADDR_LSB+31 -: 12];
    assign bus.index        = instr_q[ADDR_LSB+19 -: 14];
    assign bus.offset       = instr_q[ADDR_LSB+5 -: 6];
    assign bus.sel_d        = sel_d_q;
    assign bus.sel_i        = sel_i_q;
    assign bus.read_enable  = rd_en_q;
    assign bus.write_enable = wr_en_q;
    assign bus.start        = start_q;
    assign bus.clear        = clear_q;
    assign bus.print        = print_q;
    assign bus.idle         = idle_q;
    assign bus.issued_count = issued_q;
endmodule

// File: tb/tb_cache_cmd_sequencer.sv
// Directed bench for cache_cmd_sequencer with a scoreboard of expected issues.
module tb_cache_cmd_sequencer;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    cache_cmd_sequencer_if #(.CMD_W(41), .CNT_W(16)) bus ();

    cache_cmd_sequencer #(.DEPTH(8), .CMD_W(41), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          kind;   // 0 cache access, 1 clear, 2 print
        logic [11:0] tag;
        logic [13:0] idx;
        logic [5:0]  off;
        logic        sd;
        logic        si;
    } exp_t;

    exp_t sb[$];
    logic prev_re = 1'b0;
    logic prev_clr = 1'b0;
    logic prev_prt = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Record the expected issue for an accepted command
    task automatic sb_push(input logic [3:0] n, input logic [31:0] addr);
        exp_t e;
        e.kind = 0;
        e.tag  = addr[31:20];
        e.idx  = addr[19:6];
        e.off  = addr[5:0];
        e.sd   = 1'b0;
        e.si   = 1'b0;
        if (n <= 4'd6) begin
            e.sd = (n != 4'd2);
            e.si = (n == 4'd2);
            sb.push_back(e);
        end else if (n == 4'd8) begin
            e.kind = 1;
            sb.push_back(e);
        end else if (n == 4'd9) begin
            e.kind = 2;
            sb.push_back(e);
        end
    endtask

    // Drive one command for a cycle; called on a falling edge
    task automatic push_cmd(input logic [3:0] n, input logic [31:0] addr, output bit acc);
        bus.cmd_in    = {n, addr, 5'b0};
        bus.cmd_valid = 1'b1;
        acc = bus.cmd_ready;
        if (acc) sb_push(n, addr);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!bus.idle && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle_wait"}, 64'(bus.idle), 64'(1));
        @(negedge clk);
    endtask

    task automatic wait_re(input string name);
        int n = 0;
        while (!bus.read_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_re_wait"}, 64'(bus.read_enable), 64'(1));
    endtask

    // Scoreboard: compare each issued operation against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (bus.read_enable || bus.write_enable)
                chk("rd_wr_exclusive", 64'(bus.read_enable && bus.write_enable), 64'(0));
            if (bus.read_enable && !prev_re) begin
                chk("sb_has_cache_entry", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_kind_cache", 64'(e.kind), 64'(0));
                    chk("sb_tag",    64'(bus.tag),    64'(e.tag));
                    chk("sb_index",  64'(bus.index),  64'(e.idx));
                    chk("sb_offset", 64'(bus.offset), 64'(e.off));
                    chk("sb_sel_d",  64'(bus.sel_d),  64'(e.sd));
                    chk("sb_sel_i",  64'(bus.sel_i),  64'(e.si));
                end
            end
            if (bus.clear && !prev_clr) begin
                chk("sb_has_clear_entry", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_kind_clear", 64'(e.kind), 64'(1));
                end
            end
            if (bus.print && !prev_prt) begin
                chk("sb_has_print_entry", 64'(sb.size() > 0), 64'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_kind_print", 64'(e.kind), 64'(2));
                end
            end
        end
        prev_re  = bus.read_enable;
        prev_clr = bus.clear;
        prev_prt = bus.print;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          clr_n, prt_n, rw_n, clr_at, prt_at, re_n;
        int          rise_cyc[$];
        logic        prev;
        logic [3:0]  t4_n [9];
        logic [31:0] a;

        rst           = 1'b0;
        bus.cmd_in    = '0;
        bus.cmd_valid = 1'b0;
        bus.hold      = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_instruction", 64'(bus.instruction), 64'({4'b1000, 37'b0}));
        chk("rst_tag",    64'(bus.tag), 64'(0));
        chk("rst_index",  64'(bus.index), 64'(0));
        chk("rst_offset", 64'(bus.offset), 64'(0));
        chk("rst_enables", 64'({bus.sel_d, bus.sel_i, bus.read_enable, bus.write_enable,
                               bus.start, bus.clear, bus.print}), 64'(0));
        chk("rst_issued", 64'(bus.issued_count), 64'(0));
        chk("rst_ready",  64'(bus.cmd_ready), 64'(1));
        chk("rst_idle",   64'(bus.idle), 64'(1));
        rst = 1'b1;
        @(negedge clk);

        // 1: single data read, 2-cycle latency to read_enable
        push_cmd(4'h0, 32'h984DE132, acc);
        chk("t1_accepted", 64'(acc), 64'(1));
        chk("t1_re_c1", 64'(bus.read_enable), 64'(0));
        @(negedge clk);
        chk("t1_re_c2", 64'(bus.read_enable), 64'(0));
        @(negedge clk);
        chk("t1_re", 64'(bus.read_enable), 64'(1));
        chk("t1_start", 64'(bus.start), 64'(1));
        chk("t1_sel_d", 64'(bus.sel_d), 64'(1));
        chk("t1_sel_i", 64'(bus.sel_i), 64'(0));
        chk("t1_tag", 64'(bus.tag), 64'(12'h984));
        chk("t1_index", 64'(bus.index), 64'(14'h3784));
        chk("t1_offset", 64'(bus.offset), 64'(6'h32));
        @(negedge clk);
        chk("t1_we", 64'(bus.write_enable), 64'(1));
        chk("t1_re_off", 64'(bus.read_enable), 64'(0));
        chk("t1_start_off", 64'(bus.start), 64'(0));
        chk("t1_sel_held", 64'(bus.sel_d), 64'(1));
        @(negedge clk);
        chk("t1_we_off", 64'(bus.write_enable), 64'(0));
        chk("t1_issued", 64'(bus.issued_count), 64'(1));
        chk("t1_idle", 64'(bus.idle), 64'(1));

        // 2: instruction fetch
        push_cmd(4'h2, 32'h846DE107, acc);
        @(negedge clk);
        @(negedge clk);
        chk("t2_re", 64'(bus.read_enable), 64'(1));
        chk("t2_sel_i", 64'(bus.sel_i), 64'(1));
        chk("t2_sel_d", 64'(bus.sel_d), 64'(0));
        chk("t2_tag", 64'(bus.tag), 64'(12'h846));
        chk("t2_index", 64'(bus.index), 64'(14'h3784));
        chk("t2_offset", 64'(bus.offset), 64'(6'h07));
        wait_idle("t2");
        chk("t2_issued", 64'(bus.issued_count), 64'(2));

        // 3: clear then print pulses, then a dropped opcode
        push_cmd(4'h8, 32'h0, acc);
        push_cmd(4'h9, 32'h0, acc);
        clr_n = 0; prt_n = 0; rw_n = 0; clr_at = -1; prt_at = -1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.clear) begin
                clr_n++;
                if (clr_at < 0) clr_at = c;
            end
            if (bus.print) begin
                prt_n++;
                if (prt_at < 0) prt_at = c;
            end
            if (bus.read_enable || bus.write_enable) rw_n++;
        end
        chk("t3_clear_len", 64'(clr_n), 64'(1));
        chk("t3_print_len", 64'(prt_n), 64'(1));
        chk("t3_no_rw", 64'(rw_n), 64'(0));
        chk("t3_clear_before_print", 64'(clr_at < prt_at), 64'(1));
        wait_idle("t3");
        chk("t3_issued", 64'(bus.issued_count), 64'(4));
        push_cmd(4'h7, 32'h12345678, acc);
        repeat (4) @(negedge clk);
        chk("t3_drop_popped", 64'(bus.instruction[40:37]), 64'(7));
        chk("t3_drop_issued", 64'(bus.issued_count), 64'(4));
        chk("t3_drop_idle", 64'(bus.idle), 64'(1));

        // 4: fill FIFO under hold, then drain in order
        t4_n = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h2, 4'h1};
        bus.hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            a = $urandom();
            push_cmd(t4_n[i], a, acc);
            chk("t4_accept", 64'(acc), 64'(i < 8));
        end
        chk("t4_full_ready", 64'(bus.cmd_ready), 64'(0));
        bus.hold = 1'b0;
        prev = bus.read_enable;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.read_enable && !prev) rise_cyc.push_back(c);
            prev = bus.read_enable;
        end
        chk("t4_issue_n", 64'(rise_cyc.size()), 64'(8));
        for (int k = 1; k < rise_cyc.size(); k++)
            chk("t4_spacing", 64'(rise_cyc[k] - rise_cyc[k-1]), 64'(3));
        chk("t4_idle", 64'(bus.idle), 64'(1));
        chk("t4_issued", 64'(bus.issued_count), 64'(12));
        chk("t4_ready", 64'(bus.cmd_ready), 64'(1));
        chk("t4_sb_drained", 64'(sb.size()), 64'(0));

        // 5: stall while read_enable is asserted
        push_cmd(4'h1, 32'hCAFE0042, acc);
        wait_re("t5");
        re_n = 1;
        bus.hold = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.read_enable) re_n++;
            if (bus.write_enable) re_n = re_n + 100;
        end
        bus.hold = 1'b0;
        @(negedge clk);
        chk("t5_re_len", 64'(re_n), 64'(5));
        chk("t5_re_off", 64'(bus.read_enable), 64'(0));
        chk("t5_we", 64'(bus.write_enable), 64'(1));
        wait_idle("t5");
        chk("t5_issued", 64'(bus.issued_count), 64'(13));

        // 6: asynchronous reset in the update phase with 3 queued
        bus.hold = 1'b1;
        push_cmd(4'h0, 32'h11111111, acc);
        push_cmd(4'h3, 32'h22222222, acc);
        push_cmd(4'h4, 32'h33333333, acc);
        push_cmd(4'h5, 32'h44444444, acc);
        bus.hold = 1'b0;
        wait_re("t6");
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        chk("t6_re", 64'(bus.read_enable), 64'(0));
        chk("t6_enables", 64'({bus.sel_d, bus.sel_i, bus.write_enable, bus.start,
                              bus.clear, bus.print}), 64'(0));
        chk("t6_instruction", 64'(bus.instruction), 64'({4'b1000, 37'b0}));
        chk("t6_tag", 64'(bus.tag), 64'(0));
        chk("t6_issued", 64'(bus.issued_count), 64'(0));
        chk("t6_ready", 64'(bus.cmd_ready), 64'(1));
        chk("t6_idle", 64'(bus.idle), 64'(1));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rw_n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.read_enable || bus.write_enable || bus.clear || bus.print) rw_n++;
        end
        chk("t6_fifo_empty", 64'(rw_n), 64'(0));
        chk("t6_idle_after", 64'(bus.idle), 64'(1));
        chk("t6_issued_after", 64'(bus.issued_count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
